manchester_enc: RTL and testbench

- Manchester transmitter; the counterpart of manchester_dec. Both run from the same osc and the same OSC_FRE/DATA_RATE pair.
- Accepts parallel words over a valid/ready handshake. Sends each word MSB first on one serial line, optionally preceded by a preamble.
- Line coding is the one manchester_dec expects: data 0 = low then high; data 1 = high then low. Line idles low.

---
 rtl/manchester_enc.sv | 149 ++++++++++++++
 tb/tb_manchester_enc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_enc.sv
// Manchester line transmitter: takes words over valid/ready and sends them MSB first,
// data 0 as low-then-high, data 1 as high-then-low, with an optional 0-bit preamble.
module manchester_enc #(
    parameter int OSC_FRE      = 32,
    parameter int DATA_RATE    = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int PREAMBLE_LEN = 0
) (
    input  logic                  osc,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  manchester_data,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int HALF   = OSC_FRE / (2 * DATA_RATE);
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int MAXB   = (DATA_WIDTH > PREAMBLE_LEN) ? DATA_WIDTH : PREAMBLE_LEN;
    localparam int BIT_W  = (MAXB > 1) ? $clog2(MAXB) : 1;

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    if (((OSC_FRE % (2 * DATA_RATE)) != 0) || (HALF < 2) || (DATA_WIDTH < 2)) begin : g_param_check
        $error("manchester_enc: OSC_FRE must be a multiple of 2*DATA_RATE, HALF >= 2, DATA_WIDTH >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HALF_W-1:0]     r_half_cnt;
    logic [HALF_W-1:0]     w_half_nxt;
    logic                  r_phase;
    logic                  w_phase_nxt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  r_line;
    logic                  w_line_nxt;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_half_end;
    logic                  w_sym_end;
    logic                  w_word_end;
    logic                  w_pre_end;
    logic                  w_accept;

    assign w_half_end = (r_half_cnt == HALF_LAST);
    assign w_sym_end  = w_half_end && r_phase;
    assign w_word_end = (r_state == S_DATA) && w_sym_end && (r_bit_cnt == DATA_LAST);
    assign w_pre_end  = (r_state == S_PREAMBLE) && w_sym_end && (r_bit_cnt == PRE_LAST);

    // Ready in the final cycle of a word lets the next one follow with no idle gap.
    assign tx_ready = (r_state == S_IDLE) || w_word_end;
    assign w_accept = tx_valid && tx_ready;

    assign manchester_data = r_line;
    assign tx_busy         = r_busy;
    assign tx_done         = r_done;

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = w_half_end ? '0 : r_half_cnt + HALF_W'(1);
        w_phase_nxt = r_phase ^ w_half_end;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_line_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_half_nxt  = '0;
                w_phase_nxt = 1'b0;
                w_bit_nxt   = '0;
                if (w_accept) begin
                    w_shift_nxt = tx_data;
                    w_state_nxt = (PREAMBLE_LEN > 0) ? S_PREAMBLE : S_DATA;
                end
            end
            S_PREAMBLE: begin
                w_line_nxt = r_phase;
                if (w_sym_end) begin
                    w_bit_nxt = w_pre_end ? '0 : r_bit_cnt + BIT_W'(1);
                    if (w_pre_end) begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // The line register trails the counters by one cycle, giving the accept-to-line latency.
                w_line_nxt = r_phase ? ~r_shift[DATA_WIDTH-1] : r_shift[DATA_WIDTH-1];
                if (w_sym_end) begin
                    if (w_word_end) begin
                        w_bit_nxt = '0;
                        if (w_accept) begin
                            w_shift_nxt = tx_data;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt   = r_bit_cnt + BIT_W'(1);
                        w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_line     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_half_cnt <= w_half_nxt;
            r_phase    <= w_phase_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_line     <= w_line_nxt;
            r_busy     <= (w_state_nxt != S_IDLE) && (r_state != S_IDLE);
            r_done     <= w_word_end;
        end
    end

endmodule

// File: tb/tb_manchester_enc.sv
// Bench for manchester_enc: one instance without preamble, one with a 4-bit preamble,
// checked by a scoreboard of hand-computed half-bit patterns.
`timescale 1ns/1ps
module tb_manchester_enc;

    localparam int HALF = 8;

    logic       osc   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic       rdy0, line0, busy0, done0;
    logic       rdy1, line1, busy1, done1;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    typedef struct {
        logic [23:0] halfs;
        int          nh;
        int          acc;
    } item_t;

    item_t        q0[$];
    item_t        q1[$];
    logic [255:0] h0 = '0;
    logic [255:0] h1 = '0;

    manchester_enc #(.OSC_FRE(32), .DATA_RATE(2), .DATA_WIDTH(8), .PREAMBLE_LEN(0)) u_dut0 (
        .osc(osc), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
        .manchester_data(line0), .tx_busy(busy0), .tx_done(done0)
    );

    manchester_enc #(.OSC_FRE(32), .DATA_RATE(2), .DATA_WIDTH(8), .PREAMBLE_LEN(4)) u_dut1 (
        .osc(osc), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
        .manchester_data(line1), .tx_busy(busy1), .tx_done(done1)
    );

    always #15.625 osc = ~osc;

    always @(posedge osc) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic score(input string nm, input item_t e, input logic [255:0] hn);
        int bad;
        int len;
        bad = 0;
        len = e.nh * HALF;
        for (int j = 0; j < len; j++) begin
            if (hn[len-1-j] !== e.halfs[e.nh-1-(j/HALF)]) bad++;
        end
        chk({nm, " line pattern bad samples"}, bad, 0);
        chk({nm, " accept-to-done cycles"}, cyc - e.acc, len);
    endtask

    always @(negedge osc) begin : mon0
        logic [255:0] hn;
        item_t        e;
        hn = {h0[254:0], line0};
        h0 <= hn;
        if (rst_n && done0) begin
            if (q0.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL dut0 unexpected tx_done at cycle %0d", cyc);
            end else begin
                e = q0.pop_front();
                score("dut0", e, hn);
            end
        end
    end

    always @(negedge osc) begin : mon1
        logic [255:0] hn;
        item_t        e;
        hn = {h1[254:0], line1};
        h1 <= hn;
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL dut1 unexpected tx_done at cycle %0d", cyc);
            end else begin
                e = q1.pop_front();
                score("dut1", e, hn);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic send(input int sel, input logic [7:0] w, input logic [23:0] halfs,
                        input int nh, input bit keep);
        int    n;
        item_t e;
        n = 0;
        if (sel == 0) begin d0 = w; v0 = 1'b1; end
        else          begin d1 = w; v1 = 1'b1; end
        while (!((sel == 0) ? rdy0 : rdy1) && n < 1000) begin
            @(negedge osc);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errs++;
            $display("FAIL dut%0d tx_ready timeout", sel);
        end else begin
            e.halfs = halfs;
            e.nh    = nh;
            e.acc   = cyc + 1;
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        @(posedge osc);
        #1;
        if (!keep) begin
            if (sel == 0) v0 = 1'b0;
            else          v1 = 1'b0;
        end
        @(negedge osc);
    endtask

    task automatic wait_done(input int sel);
        int n;
        n = 0;
        do begin
            @(negedge osc);
            n++;
        end while (!((sel == 0) ? done0 : done1) && n < 400);
        if (n >= 400) begin
            checks++;
            errs++;
            $display("FAIL dut%0d tx_done timeout", sel);
        end
    endtask

    initial begin
        // Valid held through reset release: must be accepted on the first edge.
        d0 = 8'h64;
        v0 = 1'b1;
        repeat (3) @(negedge osc);
        chk("reset tx_ready", rdy0, 1);
        chk("reset line", line0, 0);
        chk("reset tx_busy", busy0, 0);
        chk("reset tx_done", done0, 0);
        chk("reset dut1 tx_ready", rdy1, 1);
        rst_n = 1'b1;
        send(0, 8'h64, {8'h00, 16'h6965}, 16, 0);
        repeat (40) @(negedge osc);
        chk("mid-word tx_busy", busy0, 1);
        chk("mid-word tx_ready", rdy0, 0);
        wait_done(0);
        chk("single word busy at done", busy0, 0);
        @(negedge osc);
        chk("line idle after word", line0, 0);
        chk("ready after word", rdy0, 1);
        chk("done is one cycle", done0, 0);

        // Back-to-back A5 then 3C.
        send(0, 8'hA5, {8'h00, 16'h9966}, 16, 1);
        send(0, 8'h3C, {8'h00, 16'h5AA5}, 16, 0);
        chk("b2b first done at second accept", done0, 1);
        chk("b2b busy during done", busy0, 1);
        wait_done(0);
        chk("b2b busy after last", busy0, 0);

        // Chain of 00, FF, 5A with no gaps.
        send(0, 8'h00, {8'h00, 16'h5555}, 16, 1);
        send(0, 8'hFF, {8'h00, 16'hAAAA}, 16, 1);
        send(0, 8'h5A, {8'h00, 16'h6699}, 16, 0);
        wait_done(0);

        // tx_data wiggling while busy must not be captured.
        send(0, 8'h5A, {8'h00, 16'h6699}, 16, 1);
        for (int i = 0; i < 50; i++) begin
            d0 = 8'($urandom);
            @(negedge osc);
            if (i == 25) chk("ready low while busy", rdy0, 0);
        end
        v0 = 1'b0;
        wait_done(0);

        // Preamble instance: single word, then a back-to-back pair.
        send(1, 8'h80, {8'h55, 16'h9555}, 24, 0);
        wait_done(1);
        chk("pre single busy at done", busy1, 0);
        send(1, 8'h5A, {8'h55, 16'h6699}, 24, 1);
        send(1, 8'hFF, {8'h00, 16'hAAAA}, 16, 0);
        wait_done(1);
        repeat (3) @(negedge osc);

        // Reset in the second half of bit 3 of A5 (line high there).
        send(0, 8'hA5, {8'h00, 16'h9966}, 16, 0);
        repeat (58) @(negedge osc);
        chk("line before reset", line0, 1);
        #5;
        rst_n = 1'b0;
        #1;
        chk("line drops on async reset", line0, 0);
        chk("busy drops on async reset", busy0, 0);
        q0.delete();
        repeat (3) @(negedge osc);
        rst_n = 1'b1;
        #1;
        chk("ready after reset release", rdy0, 1);
        chk("busy after reset release", busy0, 0);
        @(negedge osc);
        send(0, 8'h3C, {8'h00, 16'h5AA5}, 16, 0);
        wait_done(0);
        repeat (4) @(negedge osc);

        chk("dut0 scoreboard drained", q0.size(), 0);
        chk("dut1 scoreboard drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
